// File: rtl/max6675_pkg.sv
// Shared types and frame layout for the MAX6675 reader.
// The sensor frame is 16 bits, MSB first; D0 is tri-stated by the sensor and ignored.
package max6675_pkg;

  typedef enum logic [2:0] {
    WAIT,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int BIT_DUMMY  = 15;
  localparam int TEMP_MSB   = 14;
  localparam int TEMP_LSB   = 3;
  localparam int BIT_OPEN   = 2;
  localparam int BIT_ID     = 1;

  // Counter width for a count of n cycles, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so the two flops form a real two-stage chain, not a wire.
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/max6675_reader.sv
// MAX6675 SPI read-only master: waits for conversion, clocks in one 16-bit frame,
// then publishes the temperature word and the open/frame-error flags.
module max6675_reader
  import max6675_pkg::*;
#(
  parameter int CLK_DIV   = 25,
  parameter int CS_SETUP  = 10,
  parameter int CONV_WAIT = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        so,
  output logic        cs_n,
  output logic        sck,
  output logic [15:0] temperature,
  output logic        temp_valid,
  output logic        tc_open,
  output logic        frame_err,
  output logic        busy
);

  localparam int DIV_W   = cnt_width(CLK_DIV);
  localparam int SETUP_W = cnt_width(CS_SETUP);
  localparam int WAIT_W  = cnt_width(CONV_WAIT);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CONV_WAIT - 1);
  localparam logic [3:0]         BIT_LAST   = 4'(FRAME_BITS - 1);

  state_t                r_state;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [SETUP_W-1:0]    r_setup_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [3:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;

  logic w_so_sync;
  logic w_frame_err;
  logic w_tc_open;

  sync_2ff u_so_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (so),
    .o_q   (w_so_sync)
  );

  assign w_frame_err = r_shift[BIT_DUMMY] | r_shift[BIT_ID];
  assign w_tc_open   = r_shift[BIT_OPEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT;
      r_wait_cnt  <= '0;
      r_setup_cnt <= '0;
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      // NOTE: the shift register is reset too, so an aborted frame never leaks stale bits.
      r_shift     <= '0;
      cs_n        <= 1'b1;
      sck         <= 1'b0;
      busy        <= 1'b0;
      temperature <= '0;
      temp_valid  <= 1'b0;
      tc_open     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      unique case (r_state)
        WAIT: begin
          // Hold at terminal count until enable allows the next frame.
          if (r_wait_cnt == WAIT_LAST) begin
            if (enable) begin
              r_state     <= SETUP;
              r_wait_cnt  <= '0;
              r_setup_cnt <= '0;
              cs_n        <= 1'b0;
              busy        <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        SETUP: begin
          if (r_setup_cnt == SETUP_LAST) begin
            r_state     <= HIGH;
            r_setup_cnt <= '0;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            sck         <= 1'b1;
          end else begin
            r_setup_cnt <= r_setup_cnt + SETUP_W'(1);
          end
        end
        HIGH: begin
          // Sample at the end of the high phase, well after the sensor's falling-edge update.
          if (r_div_cnt == DIV_LAST) begin
            r_state   <= LOW;
            r_div_cnt <= '0;
            r_shift   <= {r_shift[FRAME_BITS-2:0], w_so_sync};
            sck       <= 1'b0;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        LOW: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (r_bit_cnt != BIT_LAST) begin
              r_state   <= HIGH;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              sck       <= 1'b1;
            end else begin
              r_state     <= HOLD;
              r_setup_cnt <= '0;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (r_setup_cnt == SETUP_LAST) begin
            r_state     <= DONE;
            r_setup_cnt <= '0;
            cs_n        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            r_setup_cnt <= r_setup_cnt + SETUP_W'(1);
          end
        end
        DONE: begin
          frame_err <= w_frame_err;
          tc_open   <= w_tc_open;
          if (!w_frame_err && !w_tc_open) begin
            temperature <= {4'b0000, r_shift[TEMP_MSB:TEMP_LSB]};
            temp_valid  <= 1'b1;
          end
          r_state     <= WAIT;
          r_wait_cnt  <= '0;
          r_setup_cnt <= '0;
          r_div_cnt   <= '0;
          r_bit_cnt   <= '0;
        end
        default: begin
          r_state <= WAIT;
          cs_n    <= 1'b1;
          sck     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
